// File: rtl/payload_dec_pkg.sv
// Shared definitions for the payload character decoder: class indices,
// FSM states and the byte-to-class table consumed by char_class_lut.
package payload_dec_pkg;

    localparam int NUM_CLASS   = 32;
    localparam int LINE_START  = 0;
    localparam int CLS_DIGIT   = 1;
    localparam int CLS_ALPHA   = 2;
    localparam int CLS_SLASH   = 3;
    localparam int CLS_DOT     = 4;
    localparam int CLS_SPACE   = 5;
    localparam int CLS_NEWLINE = 6;
    localparam int CLS_HEX     = 7;
    localparam int CLS_J       = 8;
    localparam int CLS_S       = 9;
    localparam int CLS_P       = 10;
    localparam int CLS_LT      = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOD,
        ST_RUN,
        ST_EOD
    } state_t;

    typedef logic [255:0][NUM_CLASS-1:0] class_table_t;

    // Letters are folded to lower case here so the engines never see case.
    function automatic class_table_t build_class_table();
        class_table_t t;
        logic [7:0]   c;
        logic [7:0]   lc;
        logic         alpha;
        logic         digit;
        t = '0;
        for (int b = 0; b < 256; b++) begin
            c     = 8'(b);
            lc    = c | 8'h20;
            digit = (c >= 8'h30) && (c <= 8'h39);
            alpha = (lc >= 8'h61) && (lc <= 8'h7A);
            t[b][CLS_DIGIT]   = digit;
            t[b][CLS_ALPHA]   = alpha;
            t[b][CLS_SLASH]   = (c == 8'h2F);
            t[b][CLS_DOT]     = (c == 8'h2E);
            t[b][CLS_SPACE]   = (c == 8'h20) || (c == 8'h09);
            t[b][CLS_NEWLINE] = (c == 8'h0A);
            t[b][CLS_HEX]     = digit || (alpha && (lc <= 8'h66));
            t[b][CLS_J]       = alpha && (lc == 8'h6A);
            t[b][CLS_S]       = alpha && (lc == 8'h73);
            t[b][CLS_P]       = alpha && (lc == 8'h70);
            t[b][CLS_LT]      = (c == 8'h3C);
        end
        return t;
    endfunction

    localparam class_table_t CLASS_TABLE = build_class_table();

endpackage

// File: rtl/char_class_lut.sv
// Combinational byte to class-vector lookup; LINE_START comes from the
// caller's line-start flag rather than from the table.
module char_class_lut #(
    parameter int WIDTH = payload_dec_pkg::NUM_CLASS
) (
    input  logic [7:0]       data,
    input  logic             line_start,
    output logic [WIDTH-1:0] cls
);
    import payload_dec_pkg::*;

    logic [NUM_CLASS-1:0] row;

    always_comb begin
        row             = CLASS_TABLE[data];
        row[LINE_START] = line_start;
    end

    for (genvar k = 0; k < WIDTH; k++) begin : g_bit
        if (k < NUM_CLASS) begin : g_map
            assign cls[k] = row[k];
        end else begin : g_zero
            assign cls[k] = 1'b0;
        end
    end

endmodule

// File: rtl/payload_char_decoder.sv
// Payload framing and character-class front end for the match engines.
// Optional depth limiting is enabled with PAYLOAD_DEC_DEPTH_LIMIT_EN.
module payload_char_decoder #(
    parameter int NUM_CLASS = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_data,
    input  logic                 s_valid,
    input  logic                 s_last,
    output logic                 s_ready,
    input  logic                 hold,
    output logic                 sod,
    output logic                 en,
    output logic [NUM_CLASS-1:0] cls,
    output logic                 eod,
    output logic [CNT_W-1:0]     byte_cnt
`ifdef PAYLOAD_DEC_DEPTH_LIMIT_EN
    ,
    input  logic [CNT_W-1:0]     depth_limit
`endif
);
    import payload_dec_pkg::*;

    state_t               state;
    state_t               state_nxt;
    logic                 ready_c;
    logic                 sod_c;
    logic                 eod_c;
    logic                 accept;
    logic                 inspect;
    logic                 line_start;
    logic                 sod_q;
    logic                 eod_q;
    logic                 en_q;
    logic [NUM_CLASS-1:0] cls_c;
    logic [NUM_CLASS-1:0] cls_q;
    logic [CNT_W-1:0]     cnt_q;

    char_class_lut #(
        .WIDTH(NUM_CLASS)
    ) u_lut (
        .data      (s_data),
        .line_start(line_start),
        .cls       (cls_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready_c   = 1'b0;
        sod_c     = 1'b0;
        eod_c     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (s_valid) state_nxt = ST_SOD;
            end
            ST_SOD: begin
                sod_c     = 1'b1;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                ready_c = ~hold;
                if (s_valid && !hold && s_last) state_nxt = ST_EOD;
            end
            ST_EOD: begin
                eod_c     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = s_valid & ready_c;

`ifdef PAYLOAD_DEC_DEPTH_LIMIT_EN
    // Past the limit bytes are drained so the payload framing stays intact.
    assign inspect = (depth_limit == '0) || (cnt_q < depth_limit);
`else
    assign inspect = 1'b1;
`endif

    // sod/eod are delayed a cycle so they bracket the en window exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            sod_q      <= 1'b0;
            eod_q      <= 1'b0;
            en_q       <= 1'b0;
            cls_q      <= '0;
            cnt_q      <= '0;
            line_start <= 1'b1;
        end else begin
            sod_q <= sod_c;
            eod_q <= eod_c;
            en_q  <= accept & inspect;
            if (accept && inspect) cls_q <= cls_c;
            if (sod_c) begin
                cnt_q      <= '0;
                line_start <= 1'b1;
            end else if (accept) begin
                if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                line_start <= (s_data == 8'h0A);
            end
        end
    end

    assign s_ready  = ready_c & ~rst;
    assign sod      = sod_q & ~rst;
    assign eod      = eod_q & ~rst;
    assign en       = en_q & ~rst;
    assign cls      = rst ? '0 : cls_q;
    assign byte_cnt = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_payload_char_decoder.sv
// Directed bench for payload_char_decoder with hand-computed class vectors.
module tb_payload_char_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        hold;
    logic        sod;
    logic        en;
    logic [31:0] cls;
    logic        eod;
    logic [15:0] byte_cnt;
    logic [15:0] depth_limit;

    logic        sat_ready;
    logic        sat_sod;
    logic        sat_en;
    logic [31:0] sat_cls;
    logic        sat_eod;
    logic [1:0]  sat_cnt;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  pay[$];
    logic [31:0] exp_cls[$];
    logic [31:0] en_cls[$];
    int          en_cyc[$];
    int          sod_cyc;
    int          eod_cyc;
    int          eod_cnt;
    int          ready_low;
    int          ready_early;
    int          cnt_at_sod;
    int          cnt_at_eod;

    always #5 clk = ~clk;

    payload_char_decoder #(
        .NUM_CLASS(32),
        .CNT_W    (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .hold    (hold),
        .sod     (sod),
        .en      (en),
        .cls     (cls),
        .eod     (eod),
        .byte_cnt(byte_cnt)
`ifdef PAYLOAD_DEC_DEPTH_LIMIT_EN
        ,
        .depth_limit(depth_limit)
`endif
    );

    payload_char_decoder #(
        .NUM_CLASS(32),
        .CNT_W    (2)
    ) u_sat (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (sat_ready),
        .hold    (hold),
        .sod     (sat_sod),
        .en      (sat_en),
        .cls     (sat_cls),
        .eod     (sat_eod),
        .byte_cnt(sat_cnt)
`ifdef PAYLOAD_DEC_DEPTH_LIMIT_EN
        ,
        .depth_limit(2'd0)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cls(input string tag);
        logic [31:0] obs;
        chk({tag, "_en_count"}, 64'(en_cls.size()), 64'(exp_cls.size()));
        for (int i = 0; i < exp_cls.size(); i++) begin
            obs = (i < en_cls.size()) ? en_cls[i] : 32'hxxxx_xxxx;
            chk($sformatf("%s_cls%0d", tag, i), 64'(obs), 64'(exp_cls[i]));
        end
    endtask

    // Cycle 0 is the first negedge with s_valid raised; stops on eod.
    task automatic run(input int abort_n, input int hold_at,
                       input int hold_len, input int gap_at,
                       input int gap_len, input int budget);
        int idx;
        int n;
        n = pay.size();
        idx = 0;
        en_cls.delete();
        en_cyc.delete();
        sod_cyc = -1;
        eod_cyc = -1;
        eod_cnt = 0;
        ready_low = 0;
        ready_early = 0;
        cnt_at_sod = -1;
        cnt_at_eod = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            hold    = (cyc >= hold_at) && (cyc < hold_at + hold_len);
            s_valid = (idx < n) &&
                      !((cyc >= gap_at) && (cyc < gap_at + gap_len));
            s_data  = (idx < n) ? pay[idx] : 8'h00;
            s_last  = (idx == n - 1);
            #1;
            if (sod && sod_cyc < 0) begin
                sod_cyc    = cyc;
                cnt_at_sod = int'(byte_cnt);
            end
            if (sod_cyc < 0 && s_ready) ready_early++;
            if (sod_cyc >= 0 && idx < n && !s_ready) ready_low++;
            if (en) begin
                en_cls.push_back(cls);
                en_cyc.push_back(cyc);
            end
            if (s_valid && s_ready) idx++;
            if (eod) begin
                eod_cnt++;
                eod_cyc    = cyc;
                cnt_at_eod = int'(byte_cnt);
                break;
            end
            if (idx == abort_n) break;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        hold    = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        s_data      = 8'h00;
        s_valid     = 1'b1;
        s_last      = 1'b0;
        hold        = 1'b0;
        depth_limit = 16'd0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_sod", 64'(sod), 64'(0));
        chk("rst_en", 64'(en), 64'(0));
        chk("rst_eod", 64'(eod), 64'(0));
        chk("rst_ready", 64'(s_ready), 64'(0));
        chk("rst_cls", 64'(cls), 64'(0));
        chk("rst_cnt", 64'(byte_cnt), 64'(0));
        s_valid = 1'b0;
        rst     = 1'b0;
        repeat (2) @(negedge clk);

        // "ab/login.jsp"
        pay     = '{8'h61, 8'h62, 8'h2F, 8'h6C, 8'h6F, 8'h67,
                    8'h69, 8'h6E, 8'h2E, 8'h6A, 8'h73, 8'h70};
        exp_cls = '{32'h85, 32'h84, 32'h08, 32'h04, 32'h04, 32'h04,
                    32'h04, 32'h04, 32'h10, 32'h104, 32'h204, 32'h404};
        run(-1, -1, 0, -1, 0, 60);
        chk("login_sod_cyc", 64'(sod_cyc), 64'(2));
        chk("login_sod_cnt", 64'(cnt_at_sod), 64'(0));
        chk("login_ready_early", 64'(ready_early), 64'(0));
        chk("login_en_first", 64'(en_cyc.size() > 0 ? en_cyc[0] : -1),
            64'(3));
        chk("login_en_last",
            64'(en_cyc.size() > 0 ? en_cyc[en_cyc.size()-1] : -1),
            64'(14));
        chk("login_eod_cyc", 64'(eod_cyc), 64'(15));
        chk("login_cnt", 64'(cnt_at_eod), 64'(12));
        chk_cls("login");
        repeat (3) @(negedge clk);
        #1;
        chk("cnt_hold_after_eod", 64'(byte_cnt), 64'(12));
        chk("eod_one_cycle", 64'(eod), 64'(0));

        // LINE_START after newline
        pay     = '{8'h78, 8'h0A, 8'h59};
        exp_cls = '{32'h05, 32'h40, 32'h05};
        run(-1, -1, 0, -1, 0, 40);
        chk("nl_sod_cnt", 64'(cnt_at_sod), 64'(0));
        chk("nl_eod_cyc", 64'(eod_cyc), 64'(6));
        chk_cls("nl");

        // hold for 3 cycles and a 2-cycle valid gap mid-payload
        pay     = '{8'h61, 8'h31, 8'h20, 8'h5A, 8'h2E, 8'h35, 8'h2F, 8'h78};
        exp_cls = '{32'h85, 32'h82, 32'h20, 32'h04,
                    32'h10, 32'h82, 32'h08, 32'h04};
        run(-1, 5, 3, 10, 2, 60);
        chk("hold_ready_low", 64'(ready_low), 64'(3));
        chk("hold_en_after", 64'(en_cyc.size() > 3 ? en_cyc[3] : -1),
            64'(9));
        chk("hold_eod_cyc", 64'(eod_cyc), 64'(16));
        chk("hold_eod_cnt", 64'(eod_cnt), 64'(1));
        chk("hold_cnt", 64'(cnt_at_eod), 64'(8));
        chk_cls("hold");

        // counter saturation on the 2-bit instance
        pay = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34};
        exp_cls = '{32'h83, 32'h82, 32'h82, 32'h82, 32'h82};
        run(-1, -1, 0, -1, 0, 40);
        chk("sat_main_cnt", 64'(cnt_at_eod), 64'(5));
        chk("sat_small_cnt", 64'(sat_cnt), 64'(3));
        chk_cls("sat");

        // reset after 5 of 10 bytes
        pay = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
                8'h66, 8'h67, 8'h68, 8'h69, 8'h6A};
        run(5, -1, 0, -1, 0, 40);
        @(negedge clk);
        rst     = 1'b1;
        s_valid = 1'b1;
        #1;
        chk("abort_ready_in_rst", 64'(s_ready), 64'(0));
        chk("abort_en_in_rst", 64'(en), 64'(0));
        @(negedge clk);
        #1;
        chk("abort_sod", 64'(sod), 64'(0));
        chk("abort_en", 64'(en), 64'(0));
        chk("abort_eod", 64'(eod), 64'(0));
        chk("abort_cls", 64'(cls), 64'(0));
        chk("abort_cnt", 64'(byte_cnt), 64'(0));
        rst     = 1'b0;
        s_valid = 1'b0;
        eod_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (eod || en || sod) eod_cnt++;
        end
        chk("abort_no_eod", 64'(eod_cnt), 64'(0));

        // single-byte payload '/'
        pay     = '{8'h2F};
        exp_cls = '{32'h09};
        run(-1, -1, 0, -1, 0, 30);
        chk("single_sod_cyc", 64'(sod_cyc), 64'(2));
        chk("single_en_cyc", 64'(en_cyc.size() > 0 ? en_cyc[0] : -1),
            64'(3));
        chk("single_eod_cyc", 64'(eod_cyc), 64'(4));
        chk("single_cnt", 64'(cnt_at_eod), 64'(1));
        chk_cls("single");

`ifdef PAYLOAD_DEC_DEPTH_LIMIT_EN
        depth_limit = 16'd4;
        pay     = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65,
                    8'h66, 8'h67, 8'h68, 8'h69, 8'h6A};
        exp_cls = '{32'h85, 32'h84, 32'h84, 32'h84};
        run(-1, -1, 0, -1, 0, 60);
        chk("depth_eod_cyc", 64'(eod_cyc), 64'(13));
        chk("depth_cnt", 64'(cnt_at_eod), 64'(10));
        chk_cls("depth");
        depth_limit = 16'd0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/payload_char_decoder.md
PAYLOAD_CHAR_DECODER -- requirements
Module: payload_char_decoder

Interface
REQ-001 SHALL have parameter NUM_CLASS, default 32: width of the character-class vector driven to the engines.
REQ-002 SHALL have parameter CNT_W, default 16: width of the byte counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- s_data  in  8  payload byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  final byte of the payload.
- s_ready  out  1  byte accepted when s_valid&s_ready.
- hold  in  1  downstream stall request.
- sod  out  1  start-of-data pulse; the engines' clear.
- en  out  1  engine clock-enable; cls valid.
- cls  out  NUM_CLASS  one-hot-per-class match bits for the current byte.
- eod  out  1  end-of-data pulse; engine outputs final.
- byte_cnt  out  CNT_W  bytes accepted in the current payload.
- depth_limit  in  CNT_W  inspection depth; present only with the macro.

Function
REQ-005 SHALL implement FSM IDLE, SOD, RUN, EOD; reset state IDLE.
REQ-006 IDLE: s_ready=0; on s_valid=1 go to SOD.
REQ-007 SOD: sod=1 for exactly one cycle, s_ready=0, byte_cnt cleared to 0; next state RUN.
REQ-008 RUN: s_ready = ~hold.
REQ-009 RUN: each accepted byte SHALL produce en=1 and registered cls on the next cycle (latency 1).
REQ-010 RUN: en=0 and cls held in any cycle following no acceptance.
REQ-011 cls bit k SHALL be 1 iff the byte is in class k of the shared class table; case-folding is pre-expanded in the table.
REQ-012 cls bit 0 (LINE_START) SHALL be 1 for the first byte after SOD and for any byte immediately following an accepted 0x0A.
REQ-013 Accepting a byte with s_last=1 SHALL move to EOD.
REQ-014 EOD: eod=1 for one cycle, aligned with the cycle after the last en; s_ready=0; next state IDLE.
REQ-015 byte_cnt SHALL increment per accepted byte and saturate at all-ones without wrap.
REQ-016 byte_cnt SHALL hold its value after EOD until the next SOD.
REQ-017 Asserting hold SHALL drop s_ready in the same cycle; no byte is lost or duplicated.
REQ-018 s_valid=0 or hold=1 mid-payload SHALL NOT end the payload.
REQ-019 A single-byte payload (s_last on the first byte) SHALL give: sod, then en with LINE_START=1, then eod.

Reset
REQ-020 While rst=1, all outputs SHALL be 0: sod, en, eod, s_ready, cls, byte_cnt.
REQ-021 Reset SHALL force FSM=IDLE and line-start flag=1.
REQ-022 rst mid-payload SHALL abandon the payload without eod; the next payload begins with a fresh SOD.

Configuration
REQ-023 Macro PAYLOAD_DEC_DEPTH_LIMIT_EN defined: the depth_limit port SHALL exist.
REQ-024 With the macro, once byte_cnt==depth_limit (nonzero), further bytes are still accepted (drained) with en=0 until s_last, then EOD.
REQ-025 With the macro, depth_limit=0 means unlimited.
REQ-026 Macro undefined: no depth_limit port; every byte is inspected.

Structure
REQ-027 Shared package payload_dec_pkg SHALL hold NUM_CLASS, the LINE_START index, the FSM state typedef, and the 256xNUM_CLASS class-table constant (rule-compiler generated).
REQ-028 SHALL contain one sub-module, char_class_lut: combinational byte+line-start to class vector, using the package table.

Verification
REQ-029 Payload "ab/login.jsp" (s_last on 'p'), hold=0 -> sod at t, en t+1..t+12, eod t+13, byte_cnt=12.
REQ-030 Bytes 'x',0x0A,'Y' -> LINE_START set on en cycles 1 and 3 only.
REQ-031 hold=1 for 3 cycles mid-payload -> s_ready=0 and en=0 for those 3 cycles; byte sequence on cls unchanged.
REQ-032 rst pulsed after 5 of 10 bytes -> all outputs 0 next cycle, no eod; next payload starts with sod.
REQ-033 With macro, depth_limit=4, 10-byte payload -> 4 en pulses, all 10 bytes accepted, eod after byte 10, byte_cnt=10.
REQ-034 Single-byte payload 0x2F -> sod, one en with cls[0]=1 and the '/' class bit set, eod.
